pipe_ctrl: RTL and testbench
============================

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter FLUSH_CYCLES, default 3: number of cycles flush_o stays asserted after a redirect; legal range 1..15.
REQ-002 SHALL have parameter IRQ_VECTOR, default 32'hFFFFFFE0: redirect target on interrupt accept.
REQ-003 SHALL have port clk_i  input  1: single clock, all state on rising edge.
REQ-004 SHALL have port rst_i  input  1: reset, asynchronous, active-low.
REQ-005 SHALL have port pc_set_i  input  1: taken branch or jump from writeback.
REQ-006 SHALL have port pc_i  input  32: redirect target, valid with pc_set_i.
REQ-007 SHALL have port wb_pc_i  input  32: PC of the instruction currently in writeback.
REQ-008 SHALL have port mem_stall_i  input  1: memory stage bus wait.
REQ-009 SHALL have port halt_i  input  1: halt instruction reached writeback.
REQ-010 SHALL have port stall_o  output  5: per-stage hold, bit0=IF .. bit4=WB.
REQ-011 SHALL have port flush_o  output  4: per-stage squash, bit0=IF .. bit3=MEM.
REQ-012 SHALL have port fetch_pc_o  output  32: new fetch address.
REQ-013 SHALL have port fetch_pc_load_o  output  1: one-cycle load strobe for fetch_pc_o.
REQ-014 SHALL have port halted_o  output  1: core halted.
REQ-015 SHALL have ports irq_i input 1, irq_ack_o output 1 and epc_o output 32, present only with PIPE_CTRL_IRQ_EN.

Function
REQ-016 SHALL implement states RUN, FLUSH, HALT with a registered down-counter cnt and registered redirect_pc.
REQ-017 SHALL drive stall_o=5'h1F combinationally whenever mem_stall_i=1 or state=HALT, else 5'h00.
REQ-018 SHALL, in RUN with halt_i=1, enter HALT next cycle regardless of other inputs (priority halt > pc_set > irq > mem_stall).
REQ-019 SHALL, in RUN with pc_set_i=1 and mem_stall_i=0, capture pc_i into redirect_pc, load cnt=FLUSH_CYCLES-1 and enter FLUSH.
REQ-020 SHALL, on pc_set_i=1 with mem_stall_i=1, set a pending flag and capture pc_i, then take the redirect on the first cycle mem_stall_i=0.
REQ-021 SHALL, in FLUSH, drive flush_o=4'hF and fetch_pc_o=redirect_pc, with fetch_pc_load_o=1 only in the first FLUSH cycle.
REQ-022 SHALL decrement cnt each FLUSH cycle with mem_stall_i=0, freeze it while mem_stall_i=1, and return to RUN after the cnt=0 cycle.
REQ-023 SHALL ignore pc_set_i while in FLUSH, because squashed instructions carry no redirect.
REQ-024 SHALL, in HALT, hold halted_o=1 and flush_o=0 until reset, or until interrupt accept when enabled.
REQ-025 SHALL drive flush_o=0 and fetch_pc_load_o=0 in RUN.

Reset
REQ-026 SHALL, while rst_i=0, force state=RUN, cnt=0, pending=0, redirect_pc=0, halted_o=0, epc_o=0 and irq_ack_o=0.
REQ-027 SHALL abandon any in-progress flush or pending redirect on reset, with no fetch_pc_load_o after release.

Configuration
REQ-028 SHALL, with PIPE_CTRL_IRQ_EN defined, accept level irq_i in RUN or HALT when no higher-priority event and mem_stall_i=0.
REQ-029 SHALL, on interrupt accept, pulse irq_ack_o for one cycle, set epc_o=wb_pc_i, set redirect_pc=IRQ_VECTOR, clear halted_o and enter FLUSH.
REQ-030 SHALL, without PIPE_CTRL_IRQ_EN, omit irq_i, irq_ack_o and epc_o, and leave HALT only via reset.

Structure
REQ-031 SHALL place the pipe_state_t enum (RUN, FLUSH, HALT) and stage-index constants (STG_IF=0 .. STG_WB=4) in package bexkat1Def.
REQ-032 SHALL be a single flat module with no sub-module.

Verification
REQ-033 SHALL check: pc_set_i=1, pc_i=32'h100 for one RUN cycle -> next cycle fetch_pc_load_o=1, fetch_pc_o=32'h100, flush_o=4'hF for 3 cycles, then RUN.
REQ-034 SHALL check: pc_set_i=1 with mem_stall_i=1 for 2 cycles -> stall_o=5'h1F, no load; load of the captured pc the cycle after the stall drops.
REQ-035 SHALL check: mem_stall_i=1 for 2 cycles mid-FLUSH -> flush_o held for 5 cycles total, one fetch_pc_load_o pulse.
REQ-036 SHALL check: halt_i=1 and pc_set_i=1 together -> HALT, halted_o=1, stall_o=5'h1F, no redirect.
REQ-037 SHALL check: rst_i=0 during the second FLUSH cycle -> all outputs at reset values, RUN after release.
REQ-038 SHALL check, with PIPE_CTRL_IRQ_EN: irq_i=1 in HALT with wb_pc_i=32'h40 -> irq_ack_o pulse, epc_o=32'h40, fetch_pc_o=32'hFFFFFFE0, halted_o=0.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// bexkat1Def: shared pipeline-control state encoding and stage bit indices.
package bexkat1Def;
  typedef enum logic [1:0] {RUN, FLUSH, HALT} pipe_state_t;
  localparam int STG_IF  = 0;
  localparam int STG_ID  = 1;
  localparam int STG_EX  = 2;
  localparam int STG_MEM = 3;
  localparam int STG_WB  = 4;
endpackage

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline stall/flush/redirect/halt sequencer.
// Optional interrupt accept path enabled by PIPE_CTRL_IRQ_EN.
module pipe_ctrl
  import bexkat1Def::*;
#(
  parameter int          FLUSH_CYCLES = 3,
  parameter logic [31:0] IRQ_VECTOR   = 32'hFFFFFFE0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        pc_set_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] wb_pc_i,
  input  logic        mem_stall_i,
  input  logic        halt_i,
  output logic [4:0]  stall_o,
  output logic [3:0]  flush_o,
  output logic [31:0] fetch_pc_o,
  output logic        fetch_pc_load_o,
  output logic        halted_o
`ifdef PIPE_CTRL_IRQ_EN
  ,
  input  logic        irq_i,
  output logic        irq_ack_o,
  output logic [31:0] epc_o
`endif
);
  localparam logic [3:0] CNT_INIT = 4'(FLUSH_CYCLES - 1);
  pipe_state_t state, state_n;
  logic [3:0] cnt, cnt_n;
  logic pending, pending_n, first, first_n, irq_take;
  logic [31:0] redirect_pc, redirect_pc_n;
`ifdef PIPE_CTRL_IRQ_EN
  // Interrupts yield to halt, a new redirect and a pending redirect.
  assign irq_take = irq_i && !mem_stall_i &&
                    (state == HALT || (state == RUN && !halt_i && !pc_set_i && !pending));
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) begin
      irq_ack_o <= 1'b0;
      epc_o     <= '0;
    end else begin
      irq_ack_o <= irq_take;
      if (irq_take) epc_o <= wb_pc_i;
    end
`else
  logic unused_wb;
  assign irq_take  = 1'b0;
  assign unused_wb = ^wb_pc_i;
`endif
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) begin
      state       <= RUN;
      cnt         <= '0;
      pending     <= 1'b0;
      first       <= 1'b0;
      redirect_pc <= '0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      pending     <= pending_n;
      first       <= first_n;
      redirect_pc <= redirect_pc_n;
    end
  always_comb begin
    state_n       = state;
    cnt_n         = cnt;
    pending_n     = pending;
    first_n       = 1'b0;
    redirect_pc_n = redirect_pc;
    case (state)
      RUN:
        if (halt_i) begin
          state_n   = HALT;
          pending_n = 1'b0;
        end else if (pc_set_i) begin
          // A redirect under a bus wait is parked until the wait drops.
          redirect_pc_n = pc_i;
          pending_n     = mem_stall_i;
          if (!mem_stall_i) begin
            state_n = FLUSH;
            cnt_n   = CNT_INIT;
            first_n = 1'b1;
          end
        end else if (pending && !mem_stall_i) begin
          state_n   = FLUSH;
          cnt_n     = CNT_INIT;
          first_n   = 1'b1;
          pending_n = 1'b0;
        end else if (irq_take) begin
          state_n       = FLUSH;
          cnt_n         = CNT_INIT;
          first_n       = 1'b1;
          redirect_pc_n = IRQ_VECTOR;
        end
      FLUSH:
        if (!mem_stall_i) begin
          if (cnt == 4'd0) state_n = RUN;
          else cnt_n = cnt - 4'd1;
        end
      HALT:
        if (irq_take) begin
          state_n       = FLUSH;
          cnt_n         = CNT_INIT;
          first_n       = 1'b1;
          redirect_pc_n = IRQ_VECTOR;
        end
      default: state_n = RUN;
    endcase
  end
  assign stall_o         = (mem_stall_i || state == HALT) ? 5'h1F : 5'h00;
  assign flush_o         = (state == FLUSH) ? 4'hF : 4'h0;
  assign fetch_pc_o      = redirect_pc;
  assign fetch_pc_load_o = (state == FLUSH) && first;
  assign halted_o        = (state == HALT);
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: scoreboard bench for pipe_ctrl redirect, stall, halt and reset behaviour.
module tb_pipe_ctrl;
  logic clk_i = 1'b0;
  logic rst_i, pc_set_i, mem_stall_i, halt_i, fetch_pc_load_o, halted_o;
  logic [31:0] pc_i, wb_pc_i, fetch_pc_o;
  logic [4:0] stall_o;
  logic [3:0] flush_o;
`ifdef PIPE_CTRL_IRQ_EN
  logic irq_i, irq_ack_o;
  logic [31:0] epc_o;
`endif
  int n_cmp = 0;
  int n_err = 0;
  typedef struct {
    logic [4:0]  s;
    logic [3:0]  f;
    logic        l;
    logic        h;
    logic        cp;
    logic [31:0] pc;
  } exp_t;
  exp_t q[$];
  pipe_ctrl dut (
    .clk_i(clk_i), .rst_i(rst_i), .pc_set_i(pc_set_i), .pc_i(pc_i), .wb_pc_i(wb_pc_i),
    .mem_stall_i(mem_stall_i), .halt_i(halt_i), .stall_o(stall_o), .flush_o(flush_o),
    .fetch_pc_o(fetch_pc_o), .fetch_pc_load_o(fetch_pc_load_o), .halted_o(halted_o)
`ifdef PIPE_CTRL_IRQ_EN
    , .irq_i(irq_i), .irq_ack_o(irq_ack_o), .epc_o(epc_o)
`endif
  );
  always #5 clk_i = ~clk_i;
  task automatic chk(input string tg, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tg, got, exp);
    end
  endtask
  // Drive one cycle of stimulus, queue what the outputs must be, compare at the falling edge.
  task automatic cyc(input string tg, input logic r, input logic ps, input logic [31:0] p,
                     input logic ms, input logic hl, input logic [4:0] es, input logic [3:0] ef,
                     input logic el, input logic eh, input logic ecp, input logic [31:0] epc);
    exp_t e;
    rst_i = r; pc_set_i = ps; pc_i = p; mem_stall_i = ms; halt_i = hl;
    q.push_back('{es, ef, el, eh, ecp, epc});
    @(negedge clk_i);
    e = q.pop_front();
    chk({tg, ".stall"}, 32'(stall_o), 32'(e.s));
    chk({tg, ".flush"}, 32'(flush_o), 32'(e.f));
    chk({tg, ".load"}, 32'(fetch_pc_load_o), 32'(e.l));
    chk({tg, ".halted"}, 32'(halted_o), 32'(e.h));
    if (e.cp) chk({tg, ".pc"}, fetch_pc_o, e.pc);
    @(posedge clk_i);
    #1;
  endtask
  initial begin
    rst_i = 1'b0; pc_set_i = 1'b0; pc_i = '0; wb_pc_i = '0; mem_stall_i = 1'b0; halt_i = 1'b0;
`ifdef PIPE_CTRL_IRQ_EN
    irq_i = 1'b0;
`endif
    cyc("rst", 0, 0, 0, 0, 0, 5'h00, 4'h0, 0, 0, 1, 32'h0);
    cyc("idle", 1, 0, 0, 0, 0, 5'h00, 4'h0, 0, 0, 1, 32'h0);
    // Plain redirect, with a redirect attempt during FLUSH that must be ignored
    cyc("br.set", 1, 1, 32'h100, 0, 0, 5'h00, 4'h0, 0, 0, 0, 0);
    cyc("br.f1", 1, 0, 0, 0, 0, 5'h00, 4'hF, 1, 0, 1, 32'h100);
    cyc("br.f2", 1, 1, 32'hBAD, 0, 0, 5'h00, 4'hF, 0, 0, 1, 32'h100);
    cyc("br.f3", 1, 0, 0, 0, 0, 5'h00, 4'hF, 0, 0, 1, 32'h100);
    cyc("br.run", 1, 0, 0, 0, 0, 5'h00, 4'h0, 0, 0, 1, 32'h100);
    cyc("br.run2", 1, 0, 0, 0, 0, 5'h00, 4'h0, 0, 0, 0, 0);
    // Redirect under memory stall is parked then taken
    cyc("pd.s1", 1, 1, 32'h200, 1, 0, 5'h1F, 4'h0, 0, 0, 0, 0);
    cyc("pd.s2", 1, 1, 32'h200, 1, 0, 5'h1F, 4'h0, 0, 0, 0, 0);
    cyc("pd.drop", 1, 0, 0, 0, 0, 5'h00, 4'h0, 0, 0, 0, 0);
    cyc("pd.f1", 1, 0, 0, 0, 0, 5'h00, 4'hF, 1, 0, 1, 32'h200);
    cyc("pd.f2", 1, 0, 0, 0, 0, 5'h00, 4'hF, 0, 0, 0, 0);
    cyc("pd.f3", 1, 0, 0, 0, 0, 5'h00, 4'hF, 0, 0, 0, 0);
    cyc("pd.run", 1, 0, 0, 0, 0, 5'h00, 4'h0, 0, 0, 0, 0);
    // Memory stall mid-FLUSH stretches the flush to five cycles
    cyc("fs.set", 1, 1, 32'h300, 0, 0, 5'h00, 4'h0, 0, 0, 0, 0);
    cyc("fs.f1", 1, 0, 0, 0, 0, 5'h00, 4'hF, 1, 0, 1, 32'h300);
    cyc("fs.f2", 1, 0, 0, 1, 0, 5'h1F, 4'hF, 0, 0, 0, 0);
    cyc("fs.f3", 1, 0, 0, 1, 0, 5'h1F, 4'hF, 0, 0, 0, 0);
    cyc("fs.f4", 1, 0, 0, 0, 0, 5'h00, 4'hF, 0, 0, 0, 0);
    cyc("fs.f5", 1, 0, 0, 0, 0, 5'h00, 4'hF, 0, 0, 0, 0);
    cyc("fs.run", 1, 0, 0, 0, 0, 5'h00, 4'h0, 0, 0, 1, 32'h300);
    // Reset during the second FLUSH cycle
    cyc("rf.set", 1, 1, 32'h400, 0, 0, 5'h00, 4'h0, 0, 0, 0, 0);
    cyc("rf.f1", 1, 0, 0, 0, 0, 5'h00, 4'hF, 1, 0, 1, 32'h400);
    cyc("rf.rst", 0, 0, 0, 0, 0, 5'h00, 4'h0, 0, 0, 1, 32'h0);
    cyc("rf.r1", 1, 0, 0, 0, 0, 5'h00, 4'h0, 0, 0, 1, 32'h0);
    cyc("rf.r2", 1, 0, 0, 0, 0, 5'h00, 4'h0, 0, 0, 1, 32'h0);
    // Halt beats a simultaneous redirect
    cyc("ht.set", 1, 1, 32'h500, 0, 1, 5'h00, 4'h0, 0, 0, 0, 0);
    cyc("ht.h1", 1, 0, 0, 0, 0, 5'h1F, 4'h0, 0, 1, 1, 32'h0);
    cyc("ht.h2", 1, 1, 32'h600, 0, 0, 5'h1F, 4'h0, 0, 1, 1, 32'h0);
    cyc("ht.h3", 1, 0, 0, 0, 0, 5'h1F, 4'h0, 0, 1, 1, 32'h0);
`ifdef PIPE_CTRL_IRQ_EN
    wb_pc_i = 32'h40;
    irq_i = 1'b1;
    cyc("iq.req", 1, 0, 0, 0, 0, 5'h1F, 4'h0, 0, 1, 0, 0);
    irq_i = 1'b0;
    chk("iq.ack", 32'(irq_ack_o), 32'h1);
    chk("iq.epc", epc_o, 32'h40);
    cyc("iq.f1", 1, 0, 0, 0, 0, 5'h00, 4'hF, 1, 0, 1, 32'hFFFFFFE0);
    chk("iq.ack_end", 32'(irq_ack_o), 32'h0);
    cyc("iq.f2", 1, 0, 0, 0, 0, 5'h00, 4'hF, 0, 0, 0, 0);
    cyc("iq.f3", 1, 0, 0, 0, 0, 5'h00, 4'hF, 0, 0, 0, 0);
    cyc("iq.run", 1, 0, 0, 0, 0, 5'h00, 4'h0, 0, 0, 0, 0);
`else
    cyc("ht.rst", 0, 0, 0, 0, 0, 5'h00, 4'h0, 0, 0, 1, 32'h0);
    cyc("ht.run", 1, 0, 0, 0, 0, 5'h00, 4'h0, 0, 0, 0, 0);
`endif
    chk("sb.empty", 32'(q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
